imem_loader: RTL and testbench

- Writer side of the instruction-memory port that the fetch unit reads.
- Receives a little-endian byte stream (from the UART receiver), assembles 32-bit words and writes them sequentially into instruction RAM port A, starting at word address 0.
- Holds the CPU in reset (cpu_hold) while a program image is loading.
- Image format: 16-bit little-endian word count N, then N words of 4 bytes each, LSB first.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, word
// geometry and the header length check.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // An image may fill the RAM exactly (len == depth) but never exceed it.
    function automatic logic len_too_big(input logic [15:0] len, input int addr_w);
        return {16'd0, len} > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects bytes LSB-first; on the last byte of a word the assembled word and
// word_valid are presented combinationally so the caller can register them.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [23:0] low_bytes;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (byte_valid) begin
            case (byte_idx)
                2'd0:    low_bytes[7:0]   <= byte_data;
                2'd1:    low_bytes[15:8]  <= byte_data;
                2'd2:    low_bytes[23:16] <= byte_data;
                default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // The top byte bypasses the buffer so the RAM write follows with no stall.
    assign word       = {byte_data, low_bytes};
    assign word_valid = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image from a byte stream into
// instruction RAM port A, holding the CPU in reset while loading.
//
// state | meaning
// IDLE  | waiting for start, CPU released
// LEN0  | expecting word-count low byte
// LEN1  | expecting word-count high byte, range check
// DATA  | packing bytes into words, one RAM write per word
// DONE  | one-cycle completion pulse, CPU released
// ERR   | oversize image or byte timeout, CPU held until restarted
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       full_len;
    logic [TMR_W-1:0]  tmr;
    logic [ADDR_W-1:0] word_addr;
    logic [CNT_W-1:0]  words_left;
    logic              tmr_expired;
    logic              pack_clear;
    logic              pack_valid;
    logic [31:0]       pack_word;
    logic              pack_word_valid;

    assign full_len    = {rx_data, len_lo};
    assign tmr_expired = (tmr == TMR_W'(1));
    assign pack_clear  = (state != DATA);
    assign pack_valid  = rx_valid && (state == DATA);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .word       (pack_word),
        .word_valid (pack_word_valid)
    );

    // tmr counts down the idle cycles still allowed before the load is abandoned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            len_lo       <= 8'd0;
            tmr          <= '0;
            word_addr    <= '0;
            words_left   <= '0;
            wea          <= 1'b0;
            addra        <= '0;
            dina         <= 32'd0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            wea  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        state        <= LEN0;
                        cpu_hold     <= 1'b1;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        tmr          <= TMR_LOAD;
                    end
                end
                LEN0: begin
                    if (rx_valid) begin
                        len_lo <= rx_data;
                        tmr    <= TMR_LOAD;
                        state  <= LEN1;
                    end else if (tmr_expired) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                LEN1: begin
                    if (rx_valid) begin
                        tmr <= TMR_LOAD;
                        if (full_len == 16'd0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (len_too_big(full_len, ADDR_W)) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state      <= DATA;
                            word_addr  <= '0;
                            words_left <= CNT_W'(full_len);
                        end
                    end else if (tmr_expired) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        tmr <= TMR_LOAD;
                        if (pack_word_valid) begin
                            wea          <= 1'b1;
                            addra        <= word_addr;
                            dina         <= pack_word;
                            word_addr    <= word_addr + ADDR_W'(1);
                            words_loaded <= words_loaded + CNT_W'(1);
                            words_left   <= words_left - CNT_W'(1);
                            if (words_left == CNT_W'(1)) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end
                        end
                    end else if (tmr_expired) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a table of directed loads, randomized
// loads scored by a byte-stream model, and hand-written reset/collision cases.
module tb_imem_loader;

    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        int len;
        int nsent;
        int gap;
        bit fixed_data;
        bit exp_err;
        int exp_words;
        int exp_done;
    } vec_t;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [ADDR_W-1:0] w_addr[$];
    logic [31:0]       w_data[$];
    int                w_cyc[$];
    int                done_cnt;
    int                hold_drops;
    bit                loading;
    bit                done_seen;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (wea) begin
            w_addr.push_back(addra);
            w_data.push_back(dina);
            w_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_seen = 1'b1;
        end
        if (loading && !done_seen && !done && !cpu_hold) hold_drops++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_mon();
        w_addr.delete();
        w_data.delete();
        w_cyc.delete();
        done_cnt   = 0;
        hold_drops = 0;
        done_seen  = 1'b0;
    endtask

    // Reference: what a loader obeying the image rules must do for a given stream.
    function automatic vec_t model(input int len, input int nsent, input int gap);
        vec_t v;
        bit   oversize;
        v.len        = len;
        v.nsent      = nsent;
        v.gap        = gap;
        v.fixed_data = 1'b0;
        oversize     = len > DEPTH;
        v.exp_err    = oversize || (nsent < 4 * len);
        v.exp_words  = oversize ? 0 : ((nsent / 4 < len) ? nsent / 4 : len);
        v.exp_done   = v.exp_err ? 0 : 1;
        return v;
    endfunction

    task automatic run_load(input vec_t v, input string tag);
        logic [31:0] words[$];
        logic [7:0]  q[$];
        int          g;
        int          nw;
        clear_mon();
        for (int i = 0; i < (v.nsent + 3) / 4; i++) begin
            if (v.fixed_data) words.push_back(i == 0 ? 32'h12345678 : 32'hDEADBEEF);
            else words.push_back($urandom);
        end
        q.push_back(8'(v.len));
        q.push_back(8'(v.len >> 8));
        for (int b = 0; b < v.nsent; b++) q.push_back(8'(words[b / 4] >> (8 * (b % 4))));

        pulse_start();
        check({tag, " cpu_hold after start"}, cpu_hold, 1);
        check({tag, " error cleared by start"}, error, 0);
        loading = 1'b1;
        foreach (q[i]) begin
            send_byte(q[i]);
            g = (v.gap < 0) ? int'($urandom_range(0, 3)) : v.gap;
            tick(g);
        end
        tick(TIMEOUT + 4);

        nw = w_addr.size();
        check({tag, " write count"}, nw, v.exp_words);
        for (int i = 0; i < nw && i < v.exp_words; i++) begin
            check({tag, " addra"}, w_addr[i], i);
            check({tag, " dina"}, w_data[i], words[i]);
            if (v.gap == 0 && i > 0) check({tag, " wea spacing"}, w_cyc[i] - w_cyc[i - 1], 4);
        end
        check({tag, " done pulses"}, done_cnt, v.exp_done);
        check({tag, " error"}, error, v.exp_err);
        check({tag, " cpu_hold end"}, cpu_hold, v.exp_err);
        check({tag, " words_loaded"}, words_loaded, v.exp_words);
        check({tag, " cpu_hold held"}, hold_drops, 0);
        if (!v.exp_err && v.exp_words > 0) check({tag, " addra holds"}, addra, v.exp_words - 1);
        if (v.exp_err) begin
            for (int i = 0; i < 4; i++) send_byte(8'($urandom));
            tick(4);
            check({tag, " bytes ignored in ERR"}, w_addr.size(), nw);
            check({tag, " error sticky"}, error, 1);
        end
        loading = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        loading  = 1'b0;
        clear_mon();
        #12;
        check("reset wea", wea, 0);
        check("reset addra", addra, 0);
        check("reset dina", dina, 0);
        check("reset cpu_hold", cpu_hold, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        check("reset words_loaded", words_loaded, 0);
        reset = 1'b0;
        tick(2);

        vecs.push_back('{2, 8, 0, 1'b1, 1'b0, 2, 1});
        vecs.push_back('{3, 12, 0, 1'b0, 1'b0, 3, 1});
        vecs.push_back('{0, 0, 0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{32'h4001, 8, 0, 1'b0, 1'b1, 0, 0});
        vecs.push_back('{1, 3, 0, 1'b0, 1'b1, 0, 0});
        vecs.push_back('{3, 9, 2, 1'b0, 1'b1, 2, 0});
        vecs.push_back('{2, 8, TIMEOUT - 1, 1'b0, 1'b0, 2, 1});
        vecs.push_back('{32'h4000 + 1, 0, 0, 1'b0, 1'b1, 0, 0});
        foreach (vecs[i]) run_load(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            int   len;
            int   ns;
            vec_t v;
            len = $urandom_range(1, 24);
            ns  = (i % 3 == 2) ? int'($urandom_range(0, 4 * len - 1)) : 4 * len;
            v   = model(len, ns, -1);
            run_load(v, $sformatf("rnd%0d", i));
        end

        // start and rx_valid together in IDLE: the byte must be dropped
        clear_mon();
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        pulse_start();
        rx_valid = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        tick(TIMEOUT + 4);
        check("collide done", done_cnt, 1);
        check("collide writes", w_addr.size(), 0);
        check("collide error", error, 0);

        // asynchronous reset in the middle of a 10-word load
        clear_mon();
        pulse_start();
        send_byte(8'h0A);
        send_byte(8'h00);
        for (int b = 0; b < 22; b++) send_byte(8'($urandom));
        check("pre-reset writes", w_addr.size(), 5);
        check("pre-reset words_loaded", words_loaded, 5);
        #2;
        reset = 1'b1;
        #1;
        check("async wea", wea, 0);
        check("async addra", addra, 0);
        check("async dina", dina, 0);
        check("async cpu_hold", cpu_hold, 0);
        check("async done", done, 0);
        check("async error", error, 0);
        check("async words_loaded", words_loaded, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        run_load('{1, 4, 0, 1'b0, 1'b0, 1, 1}, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
